// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte-lane writes, programmable
// wait states before OKAY data phases and a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [2:0]            HBURST,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2
  } state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic [31:0]           mem [DEPTH];
  logic [3:0]            be;
  logic                  capture, accept, legal;

  // Every beat carries its own address, so burst type and the SEQ/NONSEQ
  // distinction carry no information here.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0]};

  assign capture = HSEL & HTRANS[1] & HREADY;
  // Only states whose cycle can end a data phase may take a new address, so a
  // stray HREADY during WAIT/ERR1 can never disturb the pending transfer.
  assign accept  = capture & ((state == ST_IDLE) | (state == ST_DATA) | (state == ST_ERR2));

  always_comb begin
    legal = 1'b0;
    case (HSIZE)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~HADDR[0];
      3'd2:    legal = (HADDR[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= HADDR;
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= ST_DATA;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end else begin
            wait_cnt  <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          if (accept && !legal) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else if (accept && WAIT_STATES > 0) begin
            state     <= ST_WAIT;
            wait_cnt  <= WAIT_INIT;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b0;
          end else if (accept) begin
            state     <= ST_DATA;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be[addr_q[1:0]] = 1'b1;
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory is deliberately not reset; reset only suppresses the pending commit.
  always_ff @(posedge ACLK) begin
    if (ARESETN && state == ST_DATA && write_q) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end

  always_comb begin
    HRDATA = '0;
    if (state == ST_DATA && !write_q) HRDATA = mem[addr_q[ADDR_WIDTH-1:2]];
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
module tb_ahb_sram_slave;

  localparam int AW = 8;

  logic          aclk = 1'b0;
  logic          aresetn [2];
  logic          hsel    [2];
  logic [AW-1:0] haddr   [2];
  logic [2:0]    hburst  [2];
  logic [2:0]    hsize   [2];
  logic [1:0]    htrans  [2];
  logic          hwrite  [2];
  logic [31:0]   hwdata  [2];
  logic          hready  [2];
  logic          hreadyout [2];
  logic          hresp   [2];
  logic [31:0]   hrdata  [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
    .ACLK(aclk), .ARESETN(aresetn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HBURST(hburst[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWRITE(hwrite[0]),
    .HWDATA(hwdata[0]), .HREADY(hready[0]), .HREADYOUT(hreadyout[0]),
    .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) u_dut3 (
    .ACLK(aclk), .ARESETN(aresetn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HBURST(hburst[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWRITE(hwrite[1]),
    .HWDATA(hwdata[1]), .HREADY(hready[1]), .HREADYOUT(hreadyout[1]),
    .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = '0; hsize[d] = 3'd2;
    hwrite[d] = 1'b0; hburst[d] = 3'd0;
  endtask

  // Single non-pipelined transfer; caller sits #1 after an edge with the DUT ready.
  task automatic xfer(input int d, input logic wr, input logic [AW-1:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic rsp_lo,
                      output logic rsp_hi, output int lows);
    hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = a; hsize[d] = sz; hwrite[d] = wr;
    @(posedge aclk); #1;
    bus_idle(d);
    hwdata[d] = wd;
    lows = 0; rsp_lo = 1'b0;
    while (hreadyout[d] == 1'b0 && lows < 32) begin
      rsp_lo |= hresp[d];
      lows++;
      @(posedge aclk); #1;
    end
    rd = hrdata[d]; rsp_hi = hresp[d];
    @(posedge aclk); #1;
  endtask

  task automatic wr_word(input int d, input logic [AW-1:0] a, input logic [2:0] sz, input logic [31:0] v);
    logic [31:0] rd; logic rl, rh; int lows;
    xfer(d, 1'b1, a, sz, v, rd, rl, rh, lows);
    chk("wr_lows", 32'(lows), (d == 0) ? 32'd0 : 32'd3);
    chk("wr_resp", {31'd0, rh | rl}, 32'd0);
  endtask

  task automatic rd_chk(input int d, input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic rl, rh; int lows;
    xfer(d, 1'b0, a, 3'd2, 32'd0, rd, rl, rh, lows);
    chk(tag, rd, exp);
    chk({tag, "_resp"}, {31'd0, rh | rl}, 32'd0);
  endtask

  task automatic err_chk(input int d, input string tag, input logic [AW-1:0] a, input logic [2:0] sz);
    logic [31:0] rd; logic rl, rh; int lows;
    xfer(d, 1'b1, a, sz, 32'hFFFF_FFFF, rd, rl, rh, lows);
    chk({tag, "_lows"}, 32'(lows), 32'd1);
    chk({tag, "_resp"}, {30'd0, rl, rh}, 32'd3);
    chk({tag, "_cancel_rdy"}, {31'd0, hreadyout[d]}, 32'd1);
    chk({tag, "_cancel_resp"}, {31'd0, hresp[d]}, 32'd0);
  endtask

  initial begin
    int lows;
    logic [31:0] pdata;
    logic pend;
    int idx;

    for (int d = 0; d < 2; d++) begin
      bus_idle(d); hwdata[d] = '0; aresetn[d] = 1'b0;
    end
    repeat (3) @(posedge aclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'd0, hreadyout[d]}, 32'd1);
      chk("rst_resp", {31'd0, hresp[d]}, 32'd0);
      chk("rst_rdata", hrdata[d], 32'd0);
      aresetn[d] = 1'b1;
    end
    @(posedge aclk); #1;

    // Zero-wait pipelined write then read of the same word.
    hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 8'h14; hsize[0] = 3'd2; hwrite[0] = 1'b1;
    @(posedge aclk); #1;
    chk("zw_wr_ready", {31'd0, hreadyout[0]}, 32'd1);
    hwrite[0] = 1'b0; hwdata[0] = 32'h6434_3962;
    @(posedge aclk); #1;
    bus_idle(0);
    chk("zw_rd_ready", {31'd0, hreadyout[0]}, 32'd1);
    chk("zw_rd_resp", {31'd0, hresp[0]}, 32'd0);
    chk("zw_rd_data", hrdata[0], 32'h6434_3962);
    @(posedge aclk); #1;
    chk("zw_after_rdata", hrdata[0], 32'd0);

    // Wait states with the next address phase held through the waits.
    wr_word(1, 8'h40, 3'd2, 32'h1234_ABCD);
    wr_word(1, 8'h44, 3'd2, 32'h5555_AAAA);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 8'h40; hsize[1] = 3'd2; hwrite[1] = 1'b0;
    @(posedge aclk); #1;
    haddr[1] = 8'h44;
    lows = 0;
    while (hreadyout[1] == 1'b0 && lows < 20) begin
      chk("ws_wait_rdata", hrdata[1], 32'd0);
      lows++; @(posedge aclk); #1;
    end
    chk("ws_lows_a", 32'(lows), 32'd3);
    chk("ws_data_a", hrdata[1], 32'h1234_ABCD);
    @(posedge aclk); #1;
    bus_idle(1);
    lows = 0;
    while (hreadyout[1] == 1'b0 && lows < 20) begin
      lows++; @(posedge aclk); #1;
    end
    chk("ws_lows_b", 32'(lows), 32'd3);
    chk("ws_data_b", hrdata[1], 32'h5555_AAAA);
    @(posedge aclk); #1;

    // Byte and halfword lanes.
    wr_word(0, 8'h00, 3'd2, 32'h0000_0000);
    wr_word(0, 8'h02, 3'd0, 32'h00AB_0000);
    wr_word(0, 8'h00, 3'd1, 32'h0000_1234);
    rd_chk(0, "lanes", 8'h00, 32'h00AB_1234);
    wr_word(0, 8'h04, 3'd2, 32'h1111_2222);

    // Errors: two-cycle response, master cancels in ERR2, nothing written.
    err_chk(0, "err_hw01", 8'h01, 3'd1);
    err_chk(0, "err_w06", 8'h06, 3'd2);
    err_chk(0, "err_sz3", 8'h00, 3'd3);
    err_chk(1, "err3_w06", 8'h46, 3'd2);
    rd_chk(0, "err_rb0", 8'h00, 32'h00AB_1234);
    rd_chk(0, "err_rb4", 8'h04, 32'h1111_2222);
    rd_chk(1, "err3_rb44", 8'h44, 32'h5555_AAAA);

    // IDLE, BUSY and deselected beats must not write.
    wr_word(0, 8'h60, 3'd2, 32'hCAFE_F00D);
    for (int k = 0; k < 3; k++) begin
      hsel[0] = (k != 2); htrans[0] = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
      haddr[0] = 8'h60; hsize[0] = 3'd2; hwrite[0] = 1'b1;
      @(posedge aclk); #1;
      bus_idle(0); hwdata[0] = 32'hDEAD_BEEF;
      chk("nop_ready", {31'd0, hreadyout[0]}, 32'd1);
      chk("nop_resp", {31'd0, hresp[0]}, 32'd0);
      @(posedge aclk); #1;
    end
    rd_chk(0, "nop_rb60", 8'h60, 32'hCAFE_F00D);

    // Pipelined 8-beat incrementing write burst with a BUSY beat in the middle.
    idx = 0; pend = 1'b0; pdata = '0;
    for (int s = 0; s < 10; s++) begin
      hwdata[0] = pend ? pdata : 32'd0;
      pend = 1'b0;
      hsel[0] = 1'b1; hwrite[0] = 1'b1; hsize[0] = 3'd2;
      if (s == 4) begin
        htrans[0] = 2'b01; haddr[0] = 8'(8'h40 + 4 * idx);
      end else if (idx < 8) begin
        htrans[0] = (idx == 0) ? 2'b10 : 2'b11;
        haddr[0] = 8'(8'h40 + 4 * idx);
        pend = 1'b1; pdata = 32'hA5A5_0000 + 32'(idx);
        idx++;
      end else begin
        bus_idle(0);
      end
      @(posedge aclk); #1;
      chk("burst_ready", {31'd0, hreadyout[0]}, 32'd1);
    end
    bus_idle(0);
    for (int k = 0; k < 8; k++)
      rd_chk(0, "burst_rb", 8'(8'h40 + 4 * k), 32'hA5A5_0000 + 32'(k));
    rd_chk(0, "burst_rb60", 8'h60, 32'hCAFE_F00D);

    // Reset during the wait states of a write drops the write.
    wr_word(1, 8'h80, 3'd2, 32'h0BAD_F00D);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 8'h80; hsize[1] = 3'd2; hwrite[1] = 1'b1;
    @(posedge aclk); #1;
    bus_idle(1); hwdata[1] = 32'hFFFF_FFFF;
    chk("rstm_in_wait", {31'd0, hreadyout[1]}, 32'd0);
    aresetn[1] = 1'b0;
    @(posedge aclk); #1;
    chk("rstm_ready", {31'd0, hreadyout[1]}, 32'd1);
    chk("rstm_resp", {31'd0, hresp[1]}, 32'd0);
    chk("rstm_rdata", hrdata[1], 32'd0);
    aresetn[1] = 1'b1;
    @(posedge aclk); #1;
    rd_chk(1, "rstm_rb80", 8'h80, 32'h0BAD_F00D);
    rd_chk(1, "rstm_rb40", 8'h40, 32'h1234_ABCD);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite memory slave with programmable wait states, error signalling and byte-lane writes; the responder on the AHB side of the `axi2ahb` bridge. It holds a word-addressed SRAM of 2^(ADDR_WIDTH-2) 32-bit words. It is the standalone target that bridge-level benches load and read back through AXI bursts.

## Interface
- ADDR_WIDTH, 8, byte-address width; DEPTH = 2^(ADDR_WIDTH-2) words, so every address is in range.
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted before every OKAY data phase; legal range 0..15.
- ACLK  in  1  single clock; all state changes on rising edge.
- ARESETN  in  1  reset, synchronous and active-low.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  transfer byte address.
- HBURST  in  3  burst type; ignored, because every beat carries its own address.
- HSIZE  in  3  transfer size; 0 = byte, 1 = halfword, 2 = word, anything larger is an error.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready; in a single-slave system this is tied to HREADYOUT.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.

## Operation
- **Address-phase capture:** when HSEL & HTRANS[1] & HREADY are all high at a rising edge, latch HADDR, HSIZE and HWRITE into addr_q, size_q and write_q.
  - IDLE and BUSY beats, and unselected beats, are not captured.
  - They get a zero-wait OKAY response.
- **Legality check** at capture:
  - size 0: any address is legal.
  - size 1: HADDR[0] must be 0.
  - size 2: HADDR[1:0] must be 00.
  - size ≥ 3 or any misalignment: ERROR.
- **State machine:**
  - ST_IDLE: no data phase; HREADYOUT=1, HRESP=0.
  - ST_WAIT: count wait_cnt from WAIT_STATES-1 down to 0; HREADYOUT=0, HRESP=0; when wait_cnt=0, go to ST_DATA.
  - ST_DATA: final data cycle; HREADYOUT=1, HRESP=0; read data is valid and a pending write commits at the end of this cycle.
  - ST_ERR1: HREADYOUT=0, HRESP=1; always goes to ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=1.
- **Transitions:** from ST_IDLE, ST_DATA or ST_ERR2, a capture goes to one of:
  - ST_ERR1 if the transfer is illegal;
  - else ST_WAIT if WAIT_STATES > 0;
  - else ST_DATA.
  - With no capture, the FSM goes to ST_IDLE.
- **Write:** byte enables come from size_q and addr_q[1:0].
  - Byte: lane addr_q[1:0].
  - Halfword: lanes {addr_q[1],0} and {addr_q[1],1}.
  - Word: all four lanes.
  - mem[addr_q[ADDR_WIDTH-1:2]] is updated lane-wise from HWDATA at the rising edge that ends ST_DATA.
  - Erroring transfers never write.
- **Read:**
  - In ST_DATA with write_q=0, HRDATA = mem[addr_q word] as a full 32-bit word, regardless of size.
  - At all other times HRDATA = 0.
  - HRDATA is a combinational read from registered addr_q, so a read immediately following a write to the same word returns the new data.
- **Reset:**
  - FSM goes to ST_IDLE, wait_cnt=0, all captured registers are cleared.
  - Reset mid-transfer drops any pending write.
  - Memory contents are not cleared.

## Timing
- **Reset values:** HREADYOUT=1, HRESP=0, HRDATA=0.
- **OKAY latency:** the data phase lasts WAIT_STATES+1 cycles after the capture edge. With WAIT_STATES=0, back-to-back pipelined transfers sustain one beat per cycle.
- **ERROR** is always two cycles, (0,1) then (1,1), independent of WAIT_STATES.
- **Pipelining:**
  - A new address phase is sampled only on edges where HREADY=1, i.e. the last cycle of the previous data phase.
  - Address-phase signals presented during wait or ERR1 cycles are held by the master and sampled later.
- **Master cancel:** if the master drives HTRANS=IDLE during ST_ERR2, no capture occurs and the FSM returns to ST_IDLE.
- **Back-to-back same-address write then read:** the write commits on the same edge that captures the read, so the read data phase returns the written value.
- HREADYOUT and HRESP are registered (FSM-decoded); HRDATA is combinational from addr_q and the memory.

## Test plan
- **Zero-wait word write/read (WAIT_STATES=0):**
  - Stimulus: NONSEQ write 0x14 = 0x64343962, then NONSEQ read 0x14.
  - Required: HREADYOUT stays 1, HRESP=0, and HRDATA=0x64343962 in the read data phase, 2 cycles after the write address phase.
- **Wait states (WAIT_STATES=3):**
  - Stimulus: word read of 0x40.
  - Required: HREADYOUT is low for exactly 3 cycles, then high with valid data; the next address phase is held and captured only on the ready edge.
- **Byte and halfword lanes:**
  - Stimulus: word 0x00 = 0x00000000, then byte write 0x02 with HWDATA=0x00AB0000, then halfword write 0x00 with HWDATA=0x00001234.
  - Required: reading word 0x00 returns 0x00AB1234.
- **Errors:**
  - Stimulus: halfword at 0x01, word at 0x06, HSIZE=3 at 0x00.
  - Required: each gets HREADYOUT/HRESP = (0,1), then (1,1); memory is unchanged on readback.
- **IDLE/BUSY and HSEL=0:**
  - Stimulus: beats of each kind.
  - Required: HREADYOUT=1, HRESP=0, no write; an interleaved SEQ burst of 8 incrementing words (0x40..0x5C) reads back intact.
- **Reset mid-transfer:**
  - Stimulus: assert ARESETN=0 during ST_WAIT of a write to 0x80.
  - Required: outputs return to reset values next edge, word 0x80 keeps its old value, and previously written words persist.
